inter_packet_gap_meter: RTL and testbench

- Receive-side counterpart of the generator's inter-packet delay stage. Sits on the monitor/capture datapath.
- Measures idle clock cycles between consecutive packets on an AXI4-Stream and writes the value into the same TUSER delay field that the generator's delay stage consumes, so captured traffic can be replayed with its original timing.
- Passes traffic through a one-stage register slice.
- Keeps last/min/max gap and packet-count statistics for the register block.

---
 rtl/inter_packet_gap_meter_pkg.sv | 6 +
 rtl/axis_reg_slice_1stage.sv | 55 +++++
 rtl/inter_packet_gap_meter.sv | 101 ++++++++++
 tb/tb_inter_packet_gap_meter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/inter_packet_gap_meter_pkg.sv
// inter_packet_gap_meter_pkg: delay-field constants shared with the generator's delay stage
package inter_packet_gap_meter_pkg;
  localparam int IPD_DELAY_WIDTH = 32;
  localparam int C_TUSER_DELAY_POS_DEFAULT = 32;
  localparam logic [IPD_DELAY_WIDTH-1:0] GAP_SAT = '1;
endpackage

// File: rtl/axis_reg_slice_1stage.sv
// axis_reg_slice_1stage: single-register AXIS pipeline stage with full throughput
module axis_reg_slice_1stage #(
  parameter int DATA_WIDTH = 256,
  parameter int USER_WIDTH = 128
) (
  input  logic                    axi_aclk,
  input  logic                    axi_resetn,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tstrb,
  input  logic [USER_WIDTH-1:0]   s_tuser,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tstrb,
  output logic [USER_WIDTH-1:0]   m_tuser,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready
);
  logic                    load;
  logic                    valid_q, valid_d, last_q, last_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
  logic [USER_WIDTH-1:0]   user_q, user_d;
  assign s_tready = ~valid_q | m_tready;
  assign load     = s_tvalid & s_tready;
  always_comb begin
    valid_d = load | (valid_q & ~m_tready);
    data_d  = load ? s_tdata : data_q;
    strb_d  = load ? s_tstrb : strb_q;
    user_d  = load ? s_tuser : user_q;
    last_d  = load ? s_tlast : last_q;
  end
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
      user_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      user_q  <= user_d;
      last_q  <= last_d;
    end
  end
  assign m_tvalid = valid_q;
  assign m_tdata  = data_q;
  assign m_tstrb  = strb_q;
  assign m_tuser  = user_q;
  assign m_tlast  = last_q;
endmodule

// File: rtl/inter_packet_gap_meter.sv
// inter_packet_gap_meter: measures idle input cycles between packets, stamps the gap into
// the TUSER delay field of each first beat, and keeps last/min/max/count statistics.
module inter_packet_gap_meter
  import inter_packet_gap_meter_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_TUSER_DELAY_POS    = C_TUSER_DELAY_POS_DEFAULT
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic                              sw_rst,
  input  logic                              ipm_en,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     last_gap,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     min_gap,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     max_gap,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_count
);
  localparam int W = C_S_AXI_DATA_WIDTH;
  localparam logic [W-1:0] SAT = W'(GAP_SAT);
  logic                            in_hs, first_beat, measured;
  logic                            in_pkt_q, in_pkt_d, first_pkt_q, first_pkt_d;
  logic [W-1:0]                    gap, gap_cnt_q, gap_cnt_d;
  logic [W-1:0]                    last_gap_q, last_gap_d, min_gap_q, min_gap_d;
  logic [W-1:0]                    max_gap_q, max_gap_d, pkt_count_q, pkt_count_d;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] user_in;
  assign in_hs      = s_axis_tvalid & s_axis_tready;
  assign first_beat = in_hs & ~in_pkt_q;
  assign measured   = first_beat & ~first_pkt_q;
  always_comb begin
    gap     = first_pkt_q ? '0 : gap_cnt_q;
    user_in = s_axis_tuser;
    if (first_beat && ipm_en) user_in[C_TUSER_DELAY_POS +: IPD_DELAY_WIDTH] = IPD_DELAY_WIDTH'(gap);
    in_pkt_d    = in_hs ? ~s_axis_tlast : in_pkt_q;
    // software reset outranks a capture in the same cycle, so that packet goes uncounted
    gap_cnt_d   = (sw_rst || (in_hs && s_axis_tlast)) ? '0 :
                  (gap_cnt_q == SAT) ? gap_cnt_q : gap_cnt_q + W'(1);
    first_pkt_d = sw_rst ? 1'b1 : (first_beat ? 1'b0 : first_pkt_q);
    last_gap_d  = sw_rst ? '0 : (first_beat ? gap : last_gap_q);
    min_gap_d   = sw_rst ? SAT : ((measured && gap < min_gap_q) ? gap : min_gap_q);
    max_gap_d   = sw_rst ? '0 : ((measured && gap > max_gap_q) ? gap : max_gap_q);
    pkt_count_d = sw_rst ? '0 : pkt_count_q + W'(first_beat);
  end
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      in_pkt_q    <= 1'b0;
      first_pkt_q <= 1'b1;
      gap_cnt_q   <= '0;
      last_gap_q  <= '0;
      min_gap_q   <= SAT;
      max_gap_q   <= '0;
      pkt_count_q <= '0;
    end else begin
      in_pkt_q    <= in_pkt_d;
      first_pkt_q <= first_pkt_d;
      gap_cnt_q   <= gap_cnt_d;
      last_gap_q  <= last_gap_d;
      min_gap_q   <= min_gap_d;
      max_gap_q   <= max_gap_d;
      pkt_count_q <= pkt_count_d;
    end
  end
  assign last_gap  = last_gap_q;
  assign min_gap   = min_gap_q;
  assign max_gap   = max_gap_q;
  assign pkt_count = pkt_count_q;
  axis_reg_slice_1stage #(
    .DATA_WIDTH(C_M_AXIS_DATA_WIDTH),
    .USER_WIDTH(C_M_AXIS_TUSER_WIDTH)
  ) u_slice (
    .axi_aclk  (axi_aclk),
    .axi_resetn(axi_resetn),
    .s_tdata   (s_axis_tdata),
    .s_tstrb   (s_axis_tstrb),
    .s_tuser   (user_in),
    .s_tlast   (s_axis_tlast),
    .s_tvalid  (s_axis_tvalid),
    .s_tready  (s_axis_tready),
    .m_tdata   (m_axis_tdata),
    .m_tstrb   (m_axis_tstrb),
    .m_tuser   (m_axis_tuser),
    .m_tlast   (m_axis_tlast),
    .m_tvalid  (m_axis_tvalid),
    .m_tready  (m_axis_tready)
  );
endmodule

// File: tb/tb_inter_packet_gap_meter.sv
// tb_inter_packet_gap_meter: directed plus random stimulus against a cycle-index gap model
module tb_inter_packet_gap_meter;
  localparam logic [31:0] SAT = 32'hFFFF_FFFF;
  logic         axi_aclk = 1'b0;
  logic         axi_resetn;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tstrb;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic         sw_rst, ipm_en;
  logic [31:0]  last_gap, min_gap, max_gap, pkt_count;
  inter_packet_gap_meter dut (
    .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .sw_rst(sw_rst), .ipm_en(ipm_en),
    .last_gap(last_gap), .min_gap(min_gap), .max_gap(max_gap), .pkt_count(pkt_count)
  );
  always #5 axi_aclk = ~axi_aclk;
  int tests = 0, fails = 0;
  longint cyc = 0, last_end = 0;
  logic e_valid, e_last, m_in_pkt, m_first_pkt, loaded_first, do_force = 1'b0;
  logic [255:0] e_data;
  logic [31:0]  e_strb, m_last, m_min, m_max, m_cnt;
  logic [127:0] e_user;
  logic [31:0]  stamps[$];
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  // gap = cycles elapsed since the last accepted tlast, saturating at 32 bits
  task automatic model_step();
    longint d;
    logic [31:0] gap;
    logic ihs, first;
    cyc++;
    loaded_first = 1'b0;
    if (!axi_resetn) begin
      e_valid = 0; e_data = '0; e_strb = '0; e_user = '0; e_last = 0;
      m_in_pkt = 0; m_first_pkt = 1; m_last = 0; m_min = SAT; m_max = 0; m_cnt = 0;
      last_end = cyc;
      return;
    end
    ihs   = s_axis_tvalid && (!e_valid || m_axis_tready);
    first = ihs && !m_in_pkt;
    d     = cyc - last_end - 1;
    gap   = m_first_pkt ? 32'd0 : (d > 64'hFFFF_FFFF ? SAT : d[31:0]);
    if (ihs) begin
      e_valid = 1; e_data = s_axis_tdata; e_strb = s_axis_tstrb; e_last = s_axis_tlast;
      e_user = s_axis_tuser;
      if (first && ipm_en) e_user[63:32] = gap;
      loaded_first = first;
      m_in_pkt = !s_axis_tlast;
      if (s_axis_tlast) last_end = cyc;
    end else if (m_axis_tready) e_valid = 0;
    if (sw_rst) begin
      m_first_pkt = 1; m_last = 0; m_min = SAT; m_max = 0; m_cnt = 0; last_end = cyc;
    end else if (first) begin
      m_cnt++;
      m_last = gap;
      if (!m_first_pkt && gap < m_min) m_min = gap;
      if (!m_first_pkt && gap > m_max) m_max = gap;
      m_first_pkt = 0;
    end
    if (do_force) last_end = cyc - 64'hFFFF_FFFE;
  endtask
  task automatic compare_step();
    chk("m_tvalid", m_axis_tvalid, e_valid);
    chk("s_tready", s_axis_tready, !e_valid || m_axis_tready);
    chk("m_tdata", m_axis_tdata, e_data);
    chk("m_tstrb", m_axis_tstrb, e_strb);
    chk("m_tuser", m_axis_tuser, e_user);
    chk("m_tlast", m_axis_tlast, e_last);
    chk("last_gap", last_gap, m_last);
    chk("min_gap", min_gap, m_min);
    chk("max_gap", max_gap, m_max);
    chk("pkt_count", pkt_count, m_cnt);
    if (loaded_first) stamps.push_back(m_axis_tuser[63:32]);
  endtask
  task automatic tick();
    @(posedge axi_aclk);
    model_step();
    #1 compare_step();
    @(negedge axi_aclk);
  endtask
  task automatic present(input logic last, input logic [127:0] user);
    s_axis_tvalid = 1; s_axis_tlast = last; s_axis_tuser = user;
    for (int k = 0; k < 8; k++) s_axis_tdata[k*32 +: 32] = $urandom;
    s_axis_tstrb = $urandom;
  endtask
  task automatic wait_hs();
    int n = 0;
    logic r;
    do begin
      #1 r = s_axis_tready;
      tick();
      n++;
    end while (!r && n < 100);
    if (!r) begin
      tests++; fails++;
      $display("FAIL hs_timeout: tready still %0d after %0d cycles, want 1", r, n);
    end
    s_axis_tvalid = 0;
  endtask
  task automatic beat(input logic last, input logic [127:0] user);
    present(last, user);
    wait_hs();
  endtask
  task automatic idle(input int n);
    s_axis_tvalid = 0;
    repeat (n) tick();
  endtask
  function automatic logic [127:0] ru();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    logic hs;
    logic [127:0] u;
    axi_resetn = 0; sw_rst = 0; ipm_en = 1; m_axis_tready = 1;
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
    repeat (3) tick();
    chk("rst_min_gap", min_gap, SAT);
    chk("rst_tready", s_axis_tready, 1);
    chk("rst_tvalid", m_axis_tvalid, 0);
    axi_resetn = 1;
    tick();
    stamps.delete();
    beat(0, ru()); beat(0, ru()); beat(1, ru());
    idle(5);
    beat(0, ru()); beat(1, ru());
    chk("s1_nstamps", stamps.size(), 2);
    chk("s1_stamp0", stamps[0], 0);
    chk("s1_stamp1", stamps[1], 5);
    chk("s1_last", last_gap, 5);
    chk("s1_min", min_gap, 5);
    chk("s1_max", max_gap, 5);
    chk("s1_cnt", pkt_count, 2);
    sw_rst = 1; tick(); sw_rst = 0;
    stamps.delete();
    for (int i = 0; i < 4; i++) begin
      present(1, ru());
      #1 chk("b2b_tready", s_axis_tready, 1);
      wait_hs();
    end
    chk("b2b_nstamps", stamps.size(), 4);
    for (int i = 0; i < 4; i++) chk("b2b_stamp", stamps[i], 0);
    chk("b2b_min", min_gap, 0);
    chk("b2b_max", max_gap, 0);
    chk("b2b_cnt", pkt_count, 4);
    beat(0, ru()); beat(1, ru());
    present(1, ru());
    m_axis_tready = 0;
    #1 chk("stall_tready", s_axis_tready, 0);
    repeat (3) tick();
    m_axis_tready = 1;
    stamps.delete();
    wait_hs();
    chk("stall_stamp", stamps[0], 3);
    chk("stall_last", last_gap, 3);
    idle(2);
    ipm_en = 0;
    stamps.delete();
    u = ru(); u[63:32] = 32'hDEAD_BEEF;
    beat(1, u);
    ipm_en = 1;
    chk("noen_stamp", stamps[0], 32'hDEAD_BEEF);
    chk("noen_last", last_gap, 2);
    do_force = 1;
    force dut.gap_cnt_q = 32'hFFFF_FFFE;
    tick();
    release dut.gap_cnt_q;
    do_force = 0;
    idle(3);
    stamps.delete();
    beat(1, ru());
    chk("sat_stamp", stamps[0], SAT);
    chk("sat_last", last_gap, SAT);
    chk("sat_max", max_gap, SAT);
    idle(2);
    sw_rst = 1;
    present(0, ru());
    wait_hs();
    sw_rst = 0;
    chk("swr_cnt", pkt_count, 0);
    chk("swr_min", min_gap, SAT);
    beat(1, ru());
    idle(2);
    stamps.delete();
    beat(1, ru());
    chk("swr_stamp", stamps[0], 0);
    chk("swr_cnt1", pkt_count, 1);
    hs = 1;
    for (int i = 0; i < 3000; i++) begin
      if (hs) begin
        if ($urandom_range(0, 2) != 0) present($urandom_range(0, 2) == 0, ru());
        else s_axis_tvalid = 0;
      end
      m_axis_tready = $urandom_range(0, 3) != 0;
      ipm_en = $urandom_range(0, 7) != 0;
      sw_rst = $urandom_range(0, 150) == 0;
      #1 hs = s_axis_tvalid && s_axis_tready;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
